zeroriscy_copy_master: RTL
==========================

Name: zeroriscy_copy_master

Overview:
- Single-outstanding memory-port initiator (DMA copy engine) that drives the zero-riscy req/gnt/rvalid data interface from the master side.
- Copies LEN consecutive 32-bit words from a source word address to a destination word address, one read then one write per word.
- Attaches to a memory port (e.g. the data port of the dual-port SRAM model) and is used by benches and loaders to relocate images without core involvement.

Parameters:
- LEN_W, 16, width of the word-count input and progress counter.
- ADDR_W, 32, bus address width; addresses are byte addresses with bits [1:0] forced to 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- src_addr  in  ADDR_W  source byte address; bits [1:0] ignored
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored
- len  in  LEN_W  number of words to copy
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle completion pulse
- err_flag  out  1  sticky bus error; cleared on next accepted start
- words_done  out  LEN_W  words fully written in the current or last job
- m_req  out  1  request
- m_we  out  1  write enable
- m_be  out  4  byte enables; always 4'hF
- m_addr  out  ADDR_W  word-aligned address
- m_wdata  out  32  write data
- m_rdata  in  32  read data; valid with m_rvalid
- m_gnt  in  1  grant
- m_rvalid  in  1  response valid; returned for reads and writes
- m_err  in  1  error; qualified by m_rvalid

Behaviour:
- Reset values: busy=0, done=0, err_flag=0, words_done=0, m_req=0, m_we=0, m_be=4'hF, m_addr=0, m_wdata=0. The state machine enters IDLE.
- States:
  - IDLE: start latches src, dst and len, clears words_done and err_flag. Goes to DONE if len==0, otherwise to RD_REQ.
  - RD_REQ: m_req=1, m_we=0, m_addr=src. On m_gnt, go to RD_WAIT.
  - RD_WAIT: m_req=0. On m_rvalid, capture m_rdata into the data register.
    - If m_err: set err_flag and go to DONE.
    - Otherwise go to WR_REQ.
  - WR_REQ: m_req=1, m_we=1, m_addr=dst, m_wdata=data register. On m_gnt, go to WR_WAIT.
  - WR_WAIT: on m_rvalid, words_done+1, src+4, dst+4.
    - If m_err: set err_flag and go to DONE.
    - Else if words_done+1==len: go to DONE.
    - Otherwise go to RD_REQ.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Handshake: m_req, m_we, m_addr and m_wdata are registered outputs. They are held stable until the cycle m_gnt is sampled high, and m_req drops the cycle after grant. Only one transaction is outstanding. A gnt-free stall of any length is legal.
- Timing with gnt=1 and rvalid one cycle after request:
  - Each word takes 4 cycles.
  - done is high exactly 4*len+1 cycles after the start cycle.
  - With len==0, done comes 1 cycle after start and there is no bus activity.
- An m_rvalid arriving outside RD_WAIT or WR_WAIT is ignored.
- start while busy is ignored; latched parameters are unaffected.
- Addresses wrap modulo 2^ADDR_W.
- Overlapping ranges are copied ascending with no hazard protection; a dst above src within the range propagates data.
- Reset mid-job aborts immediately, drops m_req, and leaves no done pulse.

Optional Feature:
- Macro: ZERORISCY_COPY_CSUM_EN.
- When defined:
  - Adds output csum[31:0], the 32-bit wrapping sum of every read word captured in RD_WAIT without error.
  - csum is cleared on accepted start and reset, and holds its value after DONE.
- When undefined: port and adder are absent; behaviour is otherwise identical.

Decomposition:
- Package zeroriscy_copy_pkg holds:
  - state enum copy_state_e {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE}
  - localparams WORD_BYTES=4, BE_ALL=4'hF
- No sub-module: the FSM, address counters and data register sit in one module.

Test Plan:
- SRAM responder (gnt=1): fill 0x100..0x10C with 0x11111111..0x44444444, then start src=0x100, dst=0x200, len=4. Required: 0x200..0x20C match, done at cycle start+17, words_done=4, err_flag=0.
- len=0 start: done is high exactly 1 cycle after start, m_req never asserts, words_done=0.
- Random gnt stalls of 0..5 cycles: m_addr, m_we and m_wdata are stable while m_req=1 and gnt=0; the copy of 8 words is bit-exact.
- m_err on the 3rd read response of len=5: err_flag=1, words_done=2, done pulses, no 3rd write is issued, and the next start clears err_flag.
- start pulsed again while busy with a different len: it is ignored and the original len copy completes. Reset asserted mid-WR_REQ: m_req=0 immediately, busy=0, no done.
- With ZERORISCY_COPY_CSUM_EN: copy words 1, 2, 3, 0xFFFFFFFF; csum=0x00000005 (wrapped).

Source files
------------

// File: rtl/zeroriscy_copy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zeroriscy_copy_pkg
// Description : Shared types and constants for the zero-riscy copy master.
// Revision    : 1.0 - initial release
// ============================================================================
package zeroriscy_copy_pkg;

  // Bytes per bus word; address counters step by this amount.
  localparam int WORD_BYTES = 4;

  // Every transfer is a full 32-bit word.
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } copy_state_e;

endpackage : zeroriscy_copy_pkg
`default_nettype wire

// File: rtl/zeroriscy_copy_master.sv
`default_nettype none
// ============================================================================
// Module      : zeroriscy_copy_master
// Description : Single-outstanding DMA copy engine driving a zero-riscy style
//               req/gnt/rvalid memory port. Copies len words from src to dst,
//               one read then one write per word, ascending addresses.
//               Optional feature macro ZERORISCY_COPY_CSUM_EN adds a 32-bit
//               wrapping checksum output (csum) of all words read.
// Revision    : 1.0 - initial release
// ============================================================================
module zeroriscy_copy_master
  import zeroriscy_copy_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [LEN_W-1:0]  words_done,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic              m_err
`ifdef ZERORISCY_COPY_CSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  // Mask that forces the two byte-offset bits of an address to zero.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);

  copy_state_e       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       data_q, data_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef ZERORISCY_COPY_CSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  // State, datapath and registered bus outputs; reset aborts any job at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef ZERORISCY_COPY_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
      words_q <= words_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef ZERORISCY_COPY_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state and datapath updates: command latch, read capture, advance.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    words_d = words_q;
    err_d   = err_q;
`ifdef ZERORISCY_COPY_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr & ALIGN_MASK;
          dst_d   = dst_addr & ALIGN_MASK;
          len_d   = len;
          words_d = '0;
          err_d   = 1'b0;
`ifdef ZERORISCY_COPY_CSUM_EN
          csum_d  = '0;
`endif
          state_d = (len == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        if (m_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (m_rvalid) begin
          data_d = m_rdata;
          if (m_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
`ifdef ZERORISCY_COPY_CSUM_EN
            csum_d  = csum_q + m_rdata;
`endif
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (m_gnt) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (m_rvalid) begin
          // The write response retires the word even when it reports an error.
          words_d = words_q + LEN_W'(1);
          src_d   = src_q + ADDR_STEP;
          dst_d   = dst_q + ADDR_STEP;
          if (m_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (words_d == len_q) begin
            state_d = DONE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next-values derived from the upcoming state; request fields hold
  // stable across a stall because they only change on entry to a *_REQ state.
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    req_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == RD_REQ) begin
      we_d   = 1'b0;
      addr_d = src_d;
    end else if (state_d == WR_REQ) begin
      we_d    = 1'b1;
      addr_d  = dst_d;
      wdata_d = data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_flag   = err_q;
  assign words_done = words_q;
  assign m_req      = req_q;
  assign m_we       = we_q;
  assign m_be       = BE_ALL;
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
`ifdef ZERORISCY_COPY_CSUM_EN
  assign csum       = csum_q;
`endif

endmodule : zeroriscy_copy_master
`default_nettype wire
